// File: rtl/dense_rom_pkg.sv
// rtl/dense_rom_pkg.sv - shared types and defaults for the dense-weight ROM blocks
package dense_rom_pkg;

    localparam int ROM_ADDR_W = 7;
    localparam int ROM_DATA_W = 16;
    localparam int BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [ROM_DATA_W-1:0] data;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/dense_rom_reader_if.sv
// rtl/dense_rom_reader_if.sv - valid/ready word stream toward the dense MAC array
interface dense_rom_reader_if #(
    parameter int DATA_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/dense_skid_fifo.sv
// rtl/dense_skid_fifo.sv - 2-entry synchronous FIFO shared by the dense blocks
module dense_skid_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is only allowed when a pop frees a slot in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and saturating occupancy count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dense_rom_reader.sv
// rtl/dense_rom_reader.sv - walks a wrapping ROM address range and streams the words out
module dense_rom_reader
    import dense_rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    dense_rom_reader_if.master  strm
);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  cur_addr;
    logic [ADDR_W:0]    reads_rem;
    logic [ADDR_W:0]    pops_rem;
    logic [ADDR_W:0]    count_eff;
    logic               inflight;
    logic               inflight_last;
    logic               issue;
    logic               pop;
    logic               accept;
    logic [2:0]         occupancy;
    logic [DATA_W:0]    head;
    logic [1:0]         fifo_count;
    logic               fifo_empty;
    logic               fifo_full;

    // A zero count means one full trip around the ROM.
    assign count_eff = (count == '0) ? {1'b1, {ADDR_W{1'b0}}} : count;
    assign accept    = (state == IDLE) && start;

    assign strm.out_valid = !fifo_empty;
    assign strm.out_data  = fifo_empty ? '0 : head[DATA_W:1];
    assign strm.out_last  = fifo_empty ? 1'b0 : head[0];
    assign pop            = strm.out_valid && strm.out_ready;

    // Slots already claimed once this cycle's pop leaves; a read is only issued if its word will fit.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == RUN) && (reads_rem != '0) && (occupancy < 3'(BUF_DEPTH));

    assign rom_addr = cur_addr;
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RUN until the final read issues, DRAIN until the final word leaves.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (issue && (reads_rem == 1)) state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && (pops_rem == 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address walk, remaining counters, in-flight tracking and the done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr      <= '0;
            reads_rem     <= '0;
            pops_rem      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= (state == DRAIN) && pop && (pops_rem == 1);
            inflight      <= issue;
            inflight_last <= issue && (reads_rem == 1);
            if (accept) begin
                cur_addr  <= start_addr;
                reads_rem <= count_eff;
                pops_rem  <= count_eff;
            end else begin
                if (issue) begin
                    cur_addr  <= cur_addr + 1'b1;
                    reads_rem <= reads_rem - 1'b1;
                end
                if (pop) begin
                    pops_rem <= pops_rem - 1'b1;
                end
            end
        end
    end

    dense_skid_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data ({rom_data, inflight_last}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
